// File: rtl/dispatch8way16.sv
// Word dispatcher feeding a dmux8way16 stage: buffers one word and steers it
// to one of eight sinks, round-robin or directed, with a one-hot load strobe.
module dispatch8way16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_dest,
  input  logic             in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       chan_ready,
  output logic [2:0]       sel,
  output logic [WIDTH-1:0] out_data,
  output logic [7:0]       load,
  output logic             busy,
  output logic [15:0]      dispatch_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [2:0]       ptr;
  logic [2:0]       last_sel;
  logic [WIDTH-1:0] hold_data;
  logic [2:0]       hold_dest;
  logic             hold_mode;

  logic [2:0]       rr_target;
  logic [2:0]       target;
  logic             fire;
  logic             accept;
  logic             found;
  logic [2:0]       idx;

  // First ready channel scanning upward from ptr, wrapping mod 8.
  always_comb begin
    rr_target = ptr;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && chan_ready[idx]) begin
        rr_target = idx;
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    target = hold_mode ? hold_dest : rr_target;
    fire   = (state == FULL) &&
             (hold_mode ? chan_ready[hold_dest] : (|chan_ready));
    load   = fire ? (8'b1 << target) : '0;
    sel    = fire ? target : last_sel;
  end

  assign out_data = hold_data;
  assign in_ready = (state == EMPTY) || fire;
  assign accept   = in_valid && in_ready;
  assign busy     = (state == FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= EMPTY;
      ptr            <= '0;
      last_sel       <= '0;
      hold_data      <= '0;
      hold_dest      <= '0;
      hold_mode      <= 1'b0;
      dispatch_count <= '0;
    end else begin
      if (fire) begin
        ptr            <= target + 3'd1;
        last_sel       <= target;
        dispatch_count <= dispatch_count + 16'd1;
      end
      if (accept) begin
        hold_data <= in_data;
        hold_dest <= in_dest;
        hold_mode <= in_mode;
      end
      case (state)
        EMPTY: if (accept) state <= FULL;
        FULL:  if (fire && !accept) state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_dispatch8way16.sv
// Directed self-checking bench for dispatch8way16 using immediate assertions.
module tb_dispatch8way16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic [2:0]  in_dest;
  logic        in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  chan_ready;
  logic [2:0]  sel;
  logic [15:0] out_data;
  logic [7:0]  load;
  logic        busy;
  logic [15:0] dispatch_count;

  int n_checks = 0;
  int n_fail   = 0;
  int good_loads;

  dispatch8way16 #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dest(in_dest),
    .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .chan_ready(chan_ready), .sel(sel), .out_data(out_data), .load(load),
    .busy(busy), .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_dest = '0; in_mode = 1'b0;
    in_valid = 1'b0; chan_ready = '0;
    step(); step();
    chk("rst_load", 32'(load), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_out", 32'(out_data), 32'h0);
    chk("rst_rdy", 32'(in_ready), 32'h1);
    chk("rst_cnt", 32'(dispatch_count), 32'h0);
    rst_n = 1'b1;
    step();

    // Round-robin sweep: 9 back-to-back words
    chan_ready = 8'hFF; in_mode = 1'b0; in_valid = 1'b1; in_data = 16'h1000;
    step();
    for (int i = 0; i < 9; i++) begin
      chk("rr_load", 32'(load), 32'(8'h01 << (i % 8)));
      chk("rr_sel", 32'(sel), 32'(i % 8));
      chk("rr_out", 32'(out_data), 32'(16'h1000 + i));
      chk("rr_rdy", 32'(in_ready), 32'h1);
      if (i < 8) in_data = 16'(16'h1000 + i + 1);
      else in_valid = 1'b0;
      step();
    end
    chk("rr_cnt", 32'(dispatch_count), 32'd9);
    chk("rr_idle_load", 32'(load), 32'h00);
    chk("rr_idle_busy", 32'(busy), 32'h0);
    chk("rr_idle_sel", 32'(sel), 32'h0);

    // Directed word to channel 7 brings ptr back to 0
    in_mode = 1'b1; in_dest = 3'd7; in_data = 16'h7777; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("d7_load", 32'(load), 32'h80);
    chk("d7_sel", 32'(sel), 32'h7);
    step();

    // Round-robin skip over sparse ready mask
    chan_ready = 8'b1010_0100; in_mode = 1'b0; in_valid = 1'b1; in_data = 16'h2000;
    step();
    chk("skip0_load", 32'(load), 32'h04);
    chk("skip0_out", 32'(out_data), 32'h2000);
    in_data = 16'h2001;
    step();
    chk("skip1_load", 32'(load), 32'h20);
    chk("skip1_sel", 32'(sel), 32'h5);
    in_data = 16'h2002;
    step();
    chk("skip2_load", 32'(load), 32'h80);
    in_valid = 1'b0;
    step();
    chk("skip_idle_load", 32'(load), 32'h00);
    chk("skip_idle_sel", 32'(sel), 32'h7);
    chan_ready = 8'hFF; in_valid = 1'b1; in_data = 16'h2100;
    step();
    in_valid = 1'b0;
    chk("skip_ptr0_load", 32'(load), 32'h01);
    step();

    // Directed stall on channel 6, then release with a second word waiting
    chan_ready = 8'hBF; in_mode = 1'b1; in_dest = 3'd6; in_data = 16'hBEEF; in_valid = 1'b1;
    step();
    in_data = 16'hCAFE; in_dest = 3'd2;
    for (int k = 0; k < 5; k++) begin
      chk("stall_busy", 32'(busy), 32'h1);
      chk("stall_rdy", 32'(in_ready), 32'h0);
      chk("stall_load", 32'(load), 32'h00);
      chk("stall_out", 32'(out_data), 32'hBEEF);
      step();
    end
    chan_ready = 8'hFF;
    #1;
    chk("stall_fire_load", 32'(load), 32'h40);
    chk("stall_fire_sel", 32'(sel), 32'h6);
    chk("stall_fire_out", 32'(out_data), 32'hBEEF);
    chk("stall_fire_rdy", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    chk("second_load", 32'(load), 32'h04);
    chk("second_out", 32'(out_data), 32'hCAFE);
    step();

    // Mixed: directed to 3, then a round-robin word must go to 4
    in_mode = 1'b1; in_dest = 3'd3; in_data = 16'h3333; in_valid = 1'b1;
    step();
    in_mode = 1'b0; in_data = 16'h4444;
    chk("mix_d_load", 32'(load), 32'h08);
    step();
    in_valid = 1'b0;
    chk("mix_rr_load", 32'(load), 32'h10);
    chk("mix_rr_out", 32'(out_data), 32'h4444);
    step();
    chk("mix_cnt", 32'(dispatch_count), 32'd18);

    // Reset asserted while a directed word is stalled
    chan_ready = 8'h00; in_mode = 1'b1; in_dest = 3'd1; in_data = 16'h5555; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("prerst_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_load", 32'(load), 32'h00);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_sel", 32'(sel), 32'h0);
    chk("midrst_out", 32'(out_data), 32'h0);
    chan_ready = 8'hFF;
    #1;
    chk("midrst_load_rdy", 32'(load), 32'h00);
    step();
    rst_n = 1'b1;
    chk("postrst_cnt", 32'(dispatch_count), 32'h0);
    chk("postrst_rdy", 32'(in_ready), 32'h1);
    step();
    chk("postrst_load", 32'(load), 32'h00);
    chk("postrst_busy", 32'(busy), 32'h0);

    // Counter wrap: 65536 round-robin words back to back
    good_loads = 0;
    in_mode = 1'b0; in_valid = 1'b1; in_data = 16'h0000;
    step();
    for (int n = 0; n < 65536; n++) begin
      if (load == 8'(8'h01 << (n % 8))) good_loads++;
      if (n == 65535) begin
        chk("wrap_cnt_max", 32'(dispatch_count), 32'hFFFF);
        in_valid = 1'b0;
      end
      in_data = 16'(n + 1);
      step();
    end
    chk("wrap_loads", 32'(good_loads), 32'd65536);
    chk("wrap_cnt", 32'(dispatch_count), 32'h0000);
    chk("wrap_busy", 32'(busy), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dispatch8way16.md
# dispatch8way16

Round-robin / directed word dispatcher that sequences a `dmux8way16` fan-out stage. It accepts 16-bit words on a valid/ready input port and buffers one word. It then drives the demux `sel` and `in` together with a one-hot load strobe, so exactly one of eight destination registers or channels captures each word. It sits between a word producer (CPU write path or DMA) and a bank of eight 16-bit sinks, each of which can stall through its own ready line.

## Interface
- `WIDTH`, 16, data word width; must equal the demux width.

- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_data` input WIDTH: word to dispatch.
- `in_dest` input 3: destination channel, used only when `in_mode`=1.
- `in_mode` input 1: 0 = round-robin to the next ready channel; 1 = directed to `in_dest`.
- `in_valid` input 1: producer has a word.
- `in_ready` output 1: block accepts a word this cycle.
- `chan_ready` input 8: bit i = channel i can capture this cycle.
- `sel` output 3: drives the demux `sel`.
- `out_data` output WIDTH: drives the demux `in`.
- `load` output 8: one-hot capture strobe; all zero when idle.
- `busy` output 1: a word is held.
- `dispatch_count` output 16: number of words dispatched since reset.

## Operation
- The FSM has two states:
  - EMPTY: no word held.
  - FULL: one word held in `hold_data` with its latched `hold_dest` and `hold_mode`.
- Input accept occurs when `in_valid && in_ready`. On accept, `in_data`, `in_dest` and `in_mode` are latched.
- Target selection in FULL:
  - Directed (`hold_mode`=1): target = `hold_dest`; fire = `chan_ready[hold_dest]`.
  - Round-robin (`hold_mode`=0): target = first i in the order ptr, ptr+1, …, ptr+7 (mod 8) with `chan_ready[i]`=1; fire = |`chan_ready`.
- On fire:
  - `load[target]`=1, `sel`=target, `out_data`=`hold_data`.
  - `ptr` <= (target+1) mod 8, in both modes.
  - `last_sel` <= target.
  - `dispatch_count` increments, wrapping 0xFFFF -> 0x0000.
- When not firing: `load`=0, `sel`=`last_sel`, `out_data`=`hold_data`. The demux inputs stay steady.
- `in_ready` = (state==EMPTY) || fire. This pass-through allows one word per cycle sustained.
- State transitions:
  - EMPTY, accept -> FULL.
  - EMPTY, no accept -> EMPTY.
  - FULL, fire and accept -> FULL; the new word replaces the held word.
  - FULL, fire, no accept -> EMPTY.
  - FULL, no fire -> FULL; the held word and destination are unchanged.
- `busy` = (state==FULL).
- A directed word whose channel is stalled blocks the input indefinitely. It never falls back to another channel.

## Timing
- Reset (`rst_n` low, asynchronous) sets:
  - state EMPTY, `ptr`=0, `last_sel`=0, `hold_data`=0, `hold_dest`=0, `hold_mode`=0, `dispatch_count`=0.
  - Outputs: `sel`=0, `out_data`=0, `load`=0, `busy`=0, `in_ready`=1.
  - No word is captured while `rst_n` is low.
- Reset asserted mid-operation discards the held word with no `load` pulse. The first cycle after deassert behaves as EMPTY.
- Latency: a word accepted at edge N can fire (raise `load`) in cycle N+1 at the earliest.
- `load`, `sel` and `in_ready` are combinational from registered state and `chan_ready`. No combinational path exists from `in_valid`, `in_data` or `in_dest` to any output.
- A sink captures `out_data` at the rising edge that ends a cycle in which its `load` bit is 1.
- At most one `load` bit is high in any cycle.

## Test plan
- **Reset:** assert `rst_n`=0 mid-FULL with `chan_ready`=0x00.
  - Required: immediately `load`=0x00, `busy`=0, `sel`=0, `out_data`=0.
  - After release, `dispatch_count`=0 and `in_ready`=1.
- **Round-robin sweep:** `chan_ready`=0xFF, 9 back-to-back words 0x1000..0x1008 with `in_mode`=0.
  - Required: `load` walks 0x01, 0x02, …, 0x80, 0x01, one per cycle with no bubbles.
  - `dispatch_count`=9.
- **Round-robin skip:** `chan_ready`=0b10100100, ptr=0, three words.
  - Required: targets 2, 5, 7 in that order; then ptr=0.
- **Directed stall:** `in_mode`=1, `in_dest`=6, word 0xBEEF, `chan_ready[6]`=0 for 5 cycles, then 1.
  - Required: `busy`=1, `in_ready`=0 and `load`=0 for 5 cycles.
  - Then `load`=0x40, `sel`=6, `out_data`=0xBEEF in one cycle, and a second word is accepted in that same cycle.
- **Mixed modes:** directed to channel 3, then a round-robin word with `chan_ready`=0xFF.
  - Required: the round-robin word goes to channel 4, since ptr was advanced by the directed fire.
- **Counter wrap:** preload by dispatching 65536 words.
  - Required: `dispatch_count` returns to 0x0000 and no `load` pulse is lost.
